dcache_lsu_ctrl: RTL and testbench

//  Parametrised load/store sequencer between the Mctl-decoding memory stage and the dcache port.

---
 rtl/dcache_lsu_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_dcache_lsu_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_lsu_ctrl.sv
// Load/store sequencer between the memory stage and the dcache port; one op in flight.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two beats, otherwise they trap on exc_mis.

`ifndef MEM_NONE
`define MEM_NONE   0
`define MEM_LOAD1  1
`define MEM_LOAD2  2
`define MEM_LOAD4  3
`define MEM_LOAD1U 4
`define MEM_LOAD2U 5
`define MEM_LOAD4U 6
`define MEM_STORE1 7
`define MEM_STORE2 8
`define MEM_STORE4 9
`define MEM_INIT   10
`endif

module dcache_lsu_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MCTL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MCTL_W-1:0]      in_mctl,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_wdata,
  input  logic                   flush,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [ADDR_W-1:0]      req_addr,
  output logic                   req_we,
  output logic [DATA_W/8-1:0]    req_be,
  output logic [DATA_W-1:0]      req_wdata,
  input  logic                   rsp_valid,
  input  logic [DATA_W-1:0]      rsp_rdata,
  output logic                   ld_valid,
  output logic [DATA_W-1:0]      ld_data,
  output logic                   st_done,
  output logic                   exc_mis,
  output logic [2:0]             dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; once valid
  // is raised, the payload stays stable until that edge.
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ0 = 3'd1;
  localparam logic [2:0] RSP0 = 3'd2;
  localparam logic [2:0] REQ1 = 3'd3;
  localparam logic [2:0] RSP1 = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [MCTL_W-1:0] M_LOAD1  = MCTL_W'(`MEM_LOAD1);
  localparam logic [MCTL_W-1:0] M_LOAD2  = MCTL_W'(`MEM_LOAD2);
  localparam logic [MCTL_W-1:0] M_LOAD4  = MCTL_W'(`MEM_LOAD4);
  localparam logic [MCTL_W-1:0] M_LOAD1U = MCTL_W'(`MEM_LOAD1U);
  localparam logic [MCTL_W-1:0] M_LOAD2U = MCTL_W'(`MEM_LOAD2U);
  localparam logic [MCTL_W-1:0] M_LOAD4U = MCTL_W'(`MEM_LOAD4U);
  localparam logic [MCTL_W-1:0] M_STORE1 = MCTL_W'(`MEM_STORE1);
  localparam logic [MCTL_W-1:0] M_STORE2 = MCTL_W'(`MEM_STORE2);
  localparam logic [MCTL_W-1:0] M_STORE4 = MCTL_W'(`MEM_STORE4);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] raw0_q, raw0_d, raw1_q, raw1_d;
  logic [3:0]        size_q, size_d;
  logic              sgn_q, sgn_d, we_q, we_d;
  logic              two_q, two_d, mis_q, mis_d, drop_q, drop_d;

  logic              dec_ok, dec_we, dec_sgn, dec_mis;
  logic [3:0]        dec_size;
  logic [4:0]        span;

  // MEM_NONE, MEM_INIT and unknown codes leave dec_ok low and retire in the accept cycle.
  always_comb begin
    dec_ok   = 1'b0;
    dec_we   = 1'b0;
    dec_sgn  = 1'b0;
    dec_size = 4'd0;
    case (in_mctl)
      M_LOAD1:  begin dec_ok = 1'b1; dec_size = 4'd1; dec_sgn = 1'b1; end
      M_LOAD2:  begin dec_ok = 1'b1; dec_size = 4'd2; dec_sgn = 1'b1; end
      M_LOAD4:  begin dec_ok = 1'b1; dec_size = 4'd4; dec_sgn = 1'b1; end
      M_LOAD1U: begin dec_ok = 1'b1; dec_size = 4'd1; end
      M_LOAD2U: begin dec_ok = 1'b1; dec_size = 4'd2; end
      M_LOAD4U: begin dec_ok = 1'b1; dec_size = 4'd4; end
      M_STORE1: begin dec_ok = 1'b1; dec_size = 4'd1; dec_we = 1'b1; end
      M_STORE2: begin dec_ok = 1'b1; dec_size = 4'd2; dec_we = 1'b1; end
      M_STORE4: begin dec_ok = 1'b1; dec_size = 4'd4; dec_we = 1'b1; end
      default:  ;
    endcase
    span    = 5'(in_addr[OFF_W-1:0]) + 5'(dec_size);
    dec_mis = span > 5'(NB);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    raw0_d  = raw0_q;
    raw1_d  = raw1_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    we_d    = we_q;
    two_d   = two_q;
    mis_d   = mis_q;
    drop_d  = drop_q | (flush && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (in_valid && dec_ok) begin
          addr_d  = in_addr;
          wdata_d = in_wdata;
          size_d  = dec_size;
          sgn_d   = dec_sgn;
          we_d    = dec_we;
`ifdef MISALIGN_SPLIT_EN
          two_d   = dec_mis;
          mis_d   = 1'b0;
          state_d = REQ0;
`else
          two_d   = 1'b0;
          mis_d   = dec_mis;
          state_d = dec_mis ? DONE : REQ0;
`endif
        end
      end
      REQ0: if (req_ready) state_d = we_q ? (two_q ? REQ1 : DONE) : RSP0;
      RSP0: if (rsp_valid) begin
        raw0_d  = rsp_rdata;
        state_d = two_q ? REQ1 : DONE;
      end
      REQ1: if (req_ready) state_d = we_q ? DONE : RSP1;
      RSP1: if (rsp_valid) begin
        raw1_d  = rsp_rdata;
        state_d = DONE;
      end
      DONE: begin
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      raw0_q  <= '0;
      raw1_q  <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      we_q    <= 1'b0;
      two_q   <= 1'b0;
      mis_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      raw0_q  <= raw0_d;
      raw1_q  <= raw1_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      we_q    <= we_d;
      two_q   <= two_d;
      mis_q   <= mis_d;
      drop_q  <= drop_d;
    end
  end

  logic [OFF_W-1:0]    off_q;
  logic [ADDR_W-1:0]   word_addr;
  logic [2*NB-1:0]     be_full;
  logic [2*DATA_W-1:0] wd_full;
  logic                beat1, in_done;
  logic [DATA_W-1:0]   merged;
  logic                sbit;

  // Lanes are computed across a double word so the upper half is the second beat.
  always_comb begin
    off_q     = addr_q[OFF_W-1:0];
    word_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    be_full   = (((2*NB)'(1) << size_q) - (2*NB)'(1)) << off_q;
    wd_full   = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};
    beat1     = (state_q == REQ1) || (state_q == RSP1);
    in_done   = (state_q == DONE);
  end

  assign in_ready  = (state_q == IDLE);
  assign req_valid = (state_q == REQ0) || (state_q == REQ1);
  assign req_we    = we_q;
  assign req_addr  = beat1 ? word_addr + ADDR_W'(NB) : word_addr;
  assign req_be    = beat1 ? be_full[2*NB-1:NB] : be_full[NB-1:0];
  assign req_wdata = beat1 ? wd_full[2*DATA_W-1:DATA_W] : wd_full[DATA_W-1:0];
  assign ld_valid  = in_done && !we_q && !mis_q && !drop_q && !flush;
  assign st_done   = in_done && we_q && !mis_q;
  assign exc_mis   = in_done && mis_q;
  assign dbg_state = state_q;

  always_comb begin
    merged = DATA_W'({raw1_q, raw0_q} >> {off_q, 3'b000});
    sbit   = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (int'(size_q) == i + 1) sbit = merged[8*i+7];
    end
    for (int i = 0; i < NB; i++) begin
      ld_data[8*i +: 8] = (i < int'(size_q)) ? merged[8*i +: 8] : {8{sbit & sgn_q}};
    end
  end

endmodule

// File: tb/tb_dcache_lsu_ctrl.sv
// Directed bench for dcache_lsu_ctrl: the bench plays the memory stage and the cache.

`ifndef MEM_NONE
`define MEM_NONE   0
`define MEM_LOAD1  1
`define MEM_LOAD2  2
`define MEM_LOAD4  3
`define MEM_LOAD1U 4
`define MEM_LOAD2U 5
`define MEM_LOAD4U 6
`define MEM_STORE1 7
`define MEM_STORE2 8
`define MEM_STORE4 9
`define MEM_INIT   10
`endif

module tb_dcache_lsu_ctrl;
  localparam logic [3:0] M_NONE   = 4'(`MEM_NONE);
  localparam logic [3:0] M_LOAD1  = 4'(`MEM_LOAD1);
  localparam logic [3:0] M_LOAD2  = 4'(`MEM_LOAD2);
  localparam logic [3:0] M_LOAD4  = 4'(`MEM_LOAD4);
  localparam logic [3:0] M_LOAD1U = 4'(`MEM_LOAD1U);
  localparam logic [3:0] M_LOAD2U = 4'(`MEM_LOAD2U);
  localparam logic [3:0] M_LOAD4U = 4'(`MEM_LOAD4U);
  localparam logic [3:0] M_STORE1 = 4'(`MEM_STORE1);
  localparam logic [3:0] M_STORE2 = 4'(`MEM_STORE2);
  localparam logic [3:0] M_STORE4 = 4'(`MEM_STORE4);
  localparam logic [3:0] M_INIT   = 4'(`MEM_INIT);

  logic        clk, rst_n;
  logic        in_valid, in_ready, flush;
  logic [3:0]  in_mctl;
  logic [31:0] in_addr, in_wdata;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        ld_valid, st_done, exc_mis;
  logic [31:0] ld_data;
  logic [2:0]  dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  dcache_lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .MCTL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mctl(in_mctl),
    .in_addr(in_addr), .in_wdata(in_wdata), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ld_valid(ld_valid), .ld_data(ld_data), .st_done(st_done),
    .exc_mis(exc_mis), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: single-beat load with a zero-wait cache.
  task automatic run_load(input string tag, input logic [3:0] mctl, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] rdata, input logic [31:0] exp_data);
    exp_q.push_back(exp_data);
    check({tag, "_rdy"}, 64'(in_ready), 64'h1);
    in_valid = 1'b1; in_mctl = mctl; in_addr = addr; req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_reqv"}, 64'(req_valid), 64'h1);
    check({tag, "_addr"}, 64'(req_addr), 64'(addr & 32'hFFFF_FFFC));
    check({tag, "_be"}, 64'(req_be), 64'(be));
    check({tag, "_we"}, 64'(req_we), 64'h0);
    tick();
    check({tag, "_rspwait"}, 64'(req_valid), 64'h0);
    rsp_valid = 1'b1; rsp_rdata = rdata;
    tick();
    rsp_valid = 1'b0;
    check({tag, "_ldv"}, 64'(ld_valid), 64'h1);
    check({tag, "_ldd"}, 64'(ld_data), 64'(exp_q.pop_front()));
    tick();
    check({tag, "_ldv_off"}, 64'(ld_valid), 64'h0);
  endtask

  // Driver: single-beat store.
  task automatic run_store(input string tag, input logic [3:0] mctl, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp_wd);
    check({tag, "_rdy"}, 64'(in_ready), 64'h1);
    in_valid = 1'b1; in_mctl = mctl; in_addr = addr; in_wdata = wdata; req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_reqv"}, 64'(req_valid), 64'h1);
    check({tag, "_we"}, 64'(req_we), 64'h1);
    check({tag, "_addr"}, 64'(req_addr), 64'(addr & 32'hFFFF_FFFC));
    check({tag, "_be"}, 64'(req_be), 64'(be));
    check({tag, "_wd"}, 64'(req_wdata), 64'(exp_wd));
    tick();
    check({tag, "_std"}, 64'(st_done), 64'h1);
    check({tag, "_noldv"}, 64'(ld_valid), 64'h0);
    tick();
    check({tag, "_std_off"}, 64'(st_done), 64'h0);
    check({tag, "_idle"}, 64'(in_ready), 64'h1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mctl = '0; in_addr = '0; in_wdata = '0;
    flush = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_req_valid", 64'(req_valid), 64'h0);
    check("rst_req_addr", 64'(req_addr), 64'h0);
    check("rst_req_be", 64'(req_be), 64'h0);
    check("rst_req_wdata", 64'(req_wdata), 64'h0);
    check("rst_req_we", 64'(req_we), 64'h0);
    check("rst_ld_valid", 64'(ld_valid), 64'h0);
    check("rst_ld_data", 64'(ld_data), 64'h0);
    check("rst_st_done", 64'(st_done), 64'h0);
    check("rst_exc_mis", 64'(exc_mis), 64'h0);
    check("rst_state", 64'(dbg_state), 64'h0);
    rst_n = 1'b1;
    tick();

    // Byte/half loads: sign and zero extension from each lane
    run_load("t1", M_LOAD1, 32'h0000_1003, 4'b1000, 32'h80AA_BBCC, 32'hFFFF_FF80);
    run_load("ld2s", M_LOAD2, 32'h0000_7002, 4'b1100, 32'h9876_0000, 32'hFFFF_9876);
    run_load("ld1u", M_LOAD1U, 32'h0000_7001, 4'b0010, 32'h0000_F100, 32'h0000_00F1);
    run_load("ld2u", M_LOAD2U, 32'h0000_7000, 4'b0011, 32'hFFFF_C3C3, 32'h0000_C3C3);

    // Stores: lane shift and byte enables
    run_store("t2", M_STORE2, 32'h0000_2002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_0000);
    run_store("st1", M_STORE1, 32'h0000_2001, 32'h0000_00A5, 4'b0010, 32'h0000_A500);
    run_store("st4", M_STORE4, 32'h0000_2000, 32'h1234_5678, 4'b1111, 32'h1234_5678);

    // Request back-pressure: payload held stable while req_ready is low
    in_valid = 1'b1; in_mctl = M_LOAD4; in_addr = 32'h0000_3000; req_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t3_hold_v", 64'(req_valid), 64'h1);
      check("t3_hold_addr", 64'(req_addr), 64'h3000);
      check("t3_hold_be", 64'(req_be), 64'hF);
      check("t3_in_ready", 64'(in_ready), 64'h0);
      tick();
    end
    req_ready = 1'b1;
    check("t3_last_v", 64'(req_valid), 64'h1);
    tick();
    rsp_valid = 1'b1; rsp_rdata = 32'hDEAD_BEEF;
    tick();
    rsp_valid = 1'b0;
    check("t3_ldv", 64'(ld_valid), 64'h1);
    check("t3_ldd", 64'(ld_data), 64'hDEAD_BEEF);
    tick();
    check("t3_idle", 64'(in_ready), 64'h1);

`ifdef MISALIGN_SPLIT_EN
    // Word-crossing load split into two beats and merged
    in_valid = 1'b1; in_mctl = M_LOAD4; in_addr = 32'h0000_4002; req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t4_b0_addr", 64'(req_addr), 64'h4000);
    check("t4_b0_be", 64'(req_be), 64'hC);
    tick();
    rsp_valid = 1'b1; rsp_rdata = 32'h1111_2222;
    tick();
    rsp_valid = 1'b0;
    check("t4_b1_v", 64'(req_valid), 64'h1);
    check("t4_b1_addr", 64'(req_addr), 64'h4004);
    check("t4_b1_be", 64'(req_be), 64'h3);
    tick();
    rsp_valid = 1'b1; rsp_rdata = 32'h3333_4444;
    tick();
    rsp_valid = 1'b0;
    check("t4_ldv", 64'(ld_valid), 64'h1);
    check("t4_ldd", 64'(ld_data), 64'h4444_1111);
    tick();
    check("t4_idle", 64'(in_ready), 64'h1);
`else
    // Word-crossing accesses trap without touching the cache
    in_valid = 1'b1; in_mctl = M_LOAD4; in_addr = 32'h0000_4002; req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t4_exc", 64'(exc_mis), 64'h1);
    check("t4_noreq", 64'(req_valid), 64'h0);
    check("t4_noldv", 64'(ld_valid), 64'h0);
    check("t4_busy", 64'(in_ready), 64'h0);
    tick();
    check("t4_exc_off", 64'(exc_mis), 64'h0);
    check("t4_idle", 64'(in_ready), 64'h1);
    in_valid = 1'b1; in_mctl = M_STORE4; in_addr = 32'h0000_4001; in_wdata = 32'hCAFE_F00D;
    tick();
    in_valid = 1'b0;
    check("t4s_exc", 64'(exc_mis), 64'h1);
    check("t4s_nostd", 64'(st_done), 64'h0);
    check("t4s_noreq", 64'(req_valid), 64'h0);
    tick();
`endif

    // Flush while waiting for the response: bus completes, result dropped
    in_valid = 1'b1; in_mctl = M_LOAD2U; in_addr = 32'h0000_5000; req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t5_reqv", 64'(req_valid), 64'h1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_no_reissue", 64'(req_valid), 64'h0);
    rsp_valid = 1'b1; rsp_rdata = 32'h1234_ABCD;
    tick();
    rsp_valid = 1'b0;
    check("t5_dropped", 64'(ld_valid), 64'h0);
    tick();
    check("t5_idle", 64'(in_ready), 64'h1);
    run_load("t5_next", M_LOAD2U, 32'h0000_5002, 4'b1100, 32'h8001_0000, 32'h0000_8001);

    // Flush coincident with the response
    in_valid = 1'b1; in_mctl = M_LOAD1U; in_addr = 32'h0000_5003;
    tick();
    in_valid = 1'b0;
    tick();
    rsp_valid = 1'b1; rsp_rdata = 32'hFF00_0000; flush = 1'b1;
    tick();
    rsp_valid = 1'b0; flush = 1'b0;
    check("flrsp_dropped", 64'(ld_valid), 64'h0);
    tick();
    check("flrsp_idle", 64'(in_ready), 64'h1);

    // Flush in IDLE has no lasting effect
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_load("fl_idle", M_LOAD1, 32'h0000_5100, 4'b0001, 32'h0000_007F, 32'h0000_007F);

    // Asynchronous reset while waiting for the response
    in_valid = 1'b1; in_mctl = M_LOAD1; in_addr = 32'h0000_6000;
    tick();
    in_valid = 1'b0;
    tick();
    check("t6_in_rsp", 64'(in_ready), 64'h0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 64'(in_ready), 64'h1);
    check("t6_rst_reqv", 64'(req_valid), 64'h0);
    check("t6_rst_be", 64'(req_be), 64'h0);
    check("t6_rst_ldv", 64'(ld_valid), 64'h0);
    check("t6_rst_state", 64'(dbg_state), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_after_ready", 64'(in_ready), 64'h1);

    // Non-memory and unknown codes retire without a request or pulse
    in_valid = 1'b1; in_mctl = M_NONE; in_addr = 32'h0000_6000;
    tick();
    check("none_ready", 64'(in_ready), 64'h1);
    check("none_noreq", 64'(req_valid), 64'h0);
    in_mctl = M_INIT;
    tick();
    check("init_ready", 64'(in_ready), 64'h1);
    check("init_noreq", 64'(req_valid), 64'h0);
    in_mctl = 4'hF;
    tick();
    check("undef_ready", 64'(in_ready), 64'h1);
    check("undef_noreq", 64'(req_valid), 64'h0);
    in_valid = 1'b0;
    tick();
    check("nop_pulses", 64'({ld_valid, st_done, exc_mis}), 64'h0);
    run_load("t6_next", M_LOAD4U, 32'h0000_6004, 4'b1111, 32'h89AB_CDEF, 32'h89AB_CDEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
